// File: rtl/rename_reg_file_pkg.sv
// rename_reg_file_pkg: shared widths, constants and flattened-slice macro for rename_reg_file.
`define RRF_SLICE(v, k, w) v[(k)*(w) +: (w)]
package rename_reg_file_pkg;
  localparam int XLEN_D = 32;
  localparam int REG_W_D = 5;
  localparam int ROB_W_D = 4;
  localparam logic [31:0] NULL32 = 32'h0;
  localparam logic TRUE = 1'b1;
  localparam logic FALSE = 1'b0;
  localparam logic [ROB_W_D-1:0] ROB_NONE = '0;
endpackage

// File: rtl/rename_reg_file_clr.sv
// rename_reg_file_clr: resolves all commit ports into per-register value writes,
// tag-checked busy clears and the count of registers actually cleared.
module rename_reg_file_clr
  import rename_reg_file_pkg::*;
#(
  parameter int XLEN = XLEN_D,
  parameter int NREG = 32,
  parameter int REG_W = REG_W_D,
  parameter int ROB_W = ROB_W_D,
  parameter int NCOMMIT = 2
) (
  input  logic [NREG-1:0][ROB_W-1:0] i_tag,
  input  logic [NREG-1:0]            i_busy,
  input  logic [NCOMMIT-1:0]         i_cm_valid,
  input  logic [NCOMMIT*REG_W-1:0]   i_cm_rd,
  input  logic [NCOMMIT*ROB_W-1:0]   i_cm_tag,
  input  logic [NCOMMIT*XLEN-1:0]    i_cm_val,
  output logic [NREG-1:0]            o_we,
  output logic [NREG-1:0][XLEN-1:0]  o_val,
  output logic [NREG-1:0]            o_clr,
  output logic [REG_W:0]             o_clr_cnt
);
  // ascending port order lets the youngest port's value win; clears only count busy regs
  always_comb begin
    o_we = '0;
    o_val = '0;
    o_clr = '0;
    o_clr_cnt = '0;
    for (int r = 0; r < NREG; r++) begin
      for (int k = 0; k < NCOMMIT; k++) begin
        if (r != 0 && i_cm_valid[k] && `RRF_SLICE(i_cm_rd, k, REG_W) == REG_W'(r)) begin
          o_we[r] = TRUE;
          o_val[r] = `RRF_SLICE(i_cm_val, k, XLEN);
          if (`RRF_SLICE(i_cm_tag, k, ROB_W) == i_tag[r]) o_clr[r] = i_busy[r];
        end
      end
      o_clr_cnt = o_clr_cnt + (REG_W+1)'(o_clr[r]);
    end
  end
endmodule

// File: rtl/rename_reg_file.sv
// rename_reg_file: architectural register file with rename tags, multi-port commit and flush.
// Optional RENAME_REG_FILE_COMMIT_BYPASS_EN forwards matching same-cycle commits to the read ports.
module rename_reg_file
  import rename_reg_file_pkg::*;
#(
  parameter int XLEN = XLEN_D,
  parameter int NREG = 32,
  parameter int REG_W = REG_W_D,
  parameter int ROB_W = ROB_W_D,
  parameter int NCOMMIT = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     rdy,
  input  logic [REG_W-1:0]         rs1_idx,
  input  logic [REG_W-1:0]         rs2_idx,
  output logic [XLEN-1:0]          rs1_val,
  output logic [XLEN-1:0]          rs2_val,
  output logic                     rs1_busy,
  output logic                     rs2_busy,
  output logic [ROB_W-1:0]         rs1_tag,
  output logic [ROB_W-1:0]         rs2_tag,
  input  logic                     ren_valid,
  input  logic [REG_W-1:0]         ren_rd,
  input  logic [ROB_W-1:0]         ren_tag,
  input  logic [NCOMMIT-1:0]       cm_valid,
  input  logic [NCOMMIT*REG_W-1:0] cm_rd,
  input  logic [NCOMMIT*ROB_W-1:0] cm_tag,
  input  logic [NCOMMIT*XLEN-1:0]  cm_val,
  input  logic                     flush,
  output logic [REG_W:0]           busy_cnt
);
  logic [NREG-1:0][XLEN-1:0]  r_val;
  logic [NREG-1:0]            r_busy;
  logic [NREG-1:0][ROB_W-1:0] r_tag;
  logic [REG_W:0]             r_cnt;
  logic [NREG-1:0]            w_we;
  logic [NREG-1:0][XLEN-1:0]  w_nval;
  logic [NREG-1:0]            w_clr;
  logic [REG_W:0]             w_clr_cnt;
  logic                       w_ren;
  logic                       w_ren_new;
  logic [REG_W-1:0]           w_idx [2];
  logic [XLEN-1:0]            w_rval [2];
  logic                       w_rbusy [2];
  logic [ROB_W-1:0]           w_rtag [2];

  rename_reg_file_clr #(
    .XLEN(XLEN), .NREG(NREG), .REG_W(REG_W), .ROB_W(ROB_W), .NCOMMIT(NCOMMIT)
  ) u_clr (
    .i_tag(r_tag), .i_busy(r_busy), .i_cm_valid(cm_valid), .i_cm_rd(cm_rd),
    .i_cm_tag(cm_tag), .i_cm_val(cm_val), .o_we(w_we), .o_val(w_nval),
    .o_clr(w_clr), .o_clr_cnt(w_clr_cnt)
  );

  assign w_ren = ren_valid && ren_rd != '0;
  // a rename counts as new unless the reg stays busy; a cleared-then-renamed reg was already subtracted
  assign w_ren_new = w_ren && (!r_busy[ren_rd] || w_clr[ren_rd]);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int r = 0; r < NREG; r++) begin
        r_val[r] <= XLEN'(NULL32);
        r_tag[r] <= ROB_W'(ROB_NONE);
      end
      r_busy <= '0;
      r_cnt <= '0;
    end else if (rdy) begin
      for (int r = 0; r < NREG; r++) if (w_we[r]) r_val[r] <= w_nval[r];
      if (flush) begin
        r_busy <= '0;
        r_cnt <= '0;
      end else begin
        r_busy <= r_busy & ~w_clr;
        r_cnt <= r_cnt - w_clr_cnt + (REG_W+1)'(w_ren_new);
        if (w_ren) begin
          r_busy[ren_rd] <= TRUE;
          r_tag[ren_rd] <= ren_tag;
        end
      end
    end
  end

  assign w_idx[0] = rs1_idx;
  assign w_idx[1] = rs2_idx;

  always_comb begin
    for (int p = 0; p < 2; p++) begin
      w_rval[p] = r_val[w_idx[p]];
      w_rbusy[p] = r_busy[w_idx[p]];
      w_rtag[p] = r_tag[w_idx[p]];
`ifdef RENAME_REG_FILE_COMMIT_BYPASS_EN
      for (int k = 0; k < NCOMMIT; k++) begin
        if (cm_valid[k] && `RRF_SLICE(cm_rd, k, REG_W) == w_idx[p] &&
            `RRF_SLICE(cm_tag, k, ROB_W) == r_tag[w_idx[p]] &&
            !(ren_valid && ren_rd == w_idx[p])) begin
          w_rval[p] = `RRF_SLICE(cm_val, k, XLEN);
          w_rbusy[p] = FALSE;
        end
      end
`endif
      if (w_idx[p] == '0) begin
        w_rval[p] = XLEN'(NULL32);
        w_rbusy[p] = FALSE;
        w_rtag[p] = ROB_W'(ROB_NONE);
      end
    end
  end

  assign rs1_val = w_rval[0];
  assign rs2_val = w_rval[1];
  assign rs1_busy = w_rbusy[0];
  assign rs2_busy = w_rbusy[1];
  assign rs1_tag = w_rtag[0];
  assign rs2_tag = w_rtag[1];
  assign busy_cnt = r_cnt;
endmodule

// File: tb/tb_rename_reg_file.sv
// tb_rename_reg_file: directed and randomized checks of rename_reg_file against a behavioural model.
module tb_rename_reg_file;
  logic        clk = 1'b0;
  logic        rst, rdy, ren_valid, flush;
  logic [4:0]  rs1_idx, rs2_idx, ren_rd;
  logic [31:0] rs1_val, rs2_val;
  logic        rs1_busy, rs2_busy;
  logic [3:0]  rs1_tag, rs2_tag, ren_tag;
  logic [1:0]  cm_valid;
  logic [4:0]  c_rd [2];
  logic [3:0]  c_tag [2];
  logic [31:0] c_val [2];
  logic [9:0]  cm_rd;
  logic [7:0]  cm_tag;
  logic [63:0] cm_val;
  logic [5:0]  busy_cnt;

  logic [31:0] m_val [32];
  logic        m_busy [32];
  logic [3:0]  m_tag [32];
  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  assign cm_rd = {c_rd[1], c_rd[0]};
  assign cm_tag = {c_tag[1], c_tag[0]};
  assign cm_val = {c_val[1], c_val[0]};

  rename_reg_file dut (
    .clk(clk), .rst(rst), .rdy(rdy), .rs1_idx(rs1_idx), .rs2_idx(rs2_idx),
    .rs1_val(rs1_val), .rs2_val(rs2_val), .rs1_busy(rs1_busy), .rs2_busy(rs2_busy),
    .rs1_tag(rs1_tag), .rs2_tag(rs2_tag), .ren_valid(ren_valid), .ren_rd(ren_rd),
    .ren_tag(ren_tag), .cm_valid(cm_valid), .cm_rd(cm_rd), .cm_tag(cm_tag),
    .cm_val(cm_val), .flush(flush), .busy_cnt(busy_cnt)
  );

  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", n, a, e, $time);
    end
  endtask

  task automatic model_reset();
    for (int r = 0; r < 32; r++) begin
      m_val[r] = 0;
      m_busy[r] = 0;
      m_tag[r] = 0;
    end
  endtask

  task automatic model_step();
    logic hit [32];
    if (!rdy) return;
    for (int r = 0; r < 32; r++) hit[r] = 0;
    for (int k = 0; k < 2; k++)
      if (cm_valid[k] && c_rd[k] != 0) begin
        m_val[c_rd[k]] = c_val[k];
        if (c_tag[k] == m_tag[c_rd[k]]) hit[c_rd[k]] = 1;
      end
    if (flush) begin
      for (int r = 0; r < 32; r++) m_busy[r] = 0;
    end else begin
      for (int r = 0; r < 32; r++) if (hit[r]) m_busy[r] = 0;
      if (ren_valid && ren_rd != 0) begin
        m_busy[ren_rd] = 1;
        m_tag[ren_rd] = ren_tag;
      end
    end
  endtask

  function automatic logic [31:0] model_cnt();
    int c = 0;
    for (int r = 0; r < 32; r++) c += int'(m_busy[r]);
    return 32'(c);
  endfunction

  task automatic read_exp(input logic [4:0] idx, output logic [31:0] v, output logic b, output logic [3:0] t);
    v = (idx == 0) ? 32'h0 : m_val[idx];
    b = (idx == 0) ? 1'b0 : m_busy[idx];
    t = (idx == 0) ? 4'h0 : m_tag[idx];
`ifdef RENAME_REG_FILE_COMMIT_BYPASS_EN
    for (int k = 0; k < 2; k++)
      if (idx != 0 && cm_valid[k] && c_rd[k] == idx && c_tag[k] == m_tag[idx] &&
          !(ren_valid && ren_rd == idx)) begin
        v = c_val[k];
        b = 0;
      end
`endif
  endtask

  task automatic check_all();
    logic [31:0] v;
    logic b;
    logic [3:0] t;
    read_exp(rs1_idx, v, b, t);
    chk("rs1_val", rs1_val, v);
    chk("rs1_busy", 32'(rs1_busy), 32'(b));
    if (b) chk("rs1_tag", 32'(rs1_tag), 32'(t));
    read_exp(rs2_idx, v, b, t);
    chk("rs2_val", rs2_val, v);
    chk("rs2_busy", 32'(rs2_busy), 32'(b));
    if (b) chk("rs2_tag", 32'(rs2_tag), 32'(t));
    chk("busy_cnt", 32'(busy_cnt), model_cnt());
  endtask

  task automatic tick();
    #1 check_all();
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  task automatic idle();
    rdy = 1;
    flush = 0;
    ren_valid = 0;
    ren_rd = 0;
    ren_tag = 0;
    cm_valid = 0;
    for (int k = 0; k < 2; k++) begin
      c_rd[k] = 0;
      c_tag[k] = 0;
      c_val[k] = 0;
    end
  endtask

  task automatic ren(input logic [4:0] rd, input logic [3:0] t);
    idle();
    ren_valid = 1;
    ren_rd = rd;
    ren_tag = t;
    tick();
  endtask

  task automatic cmt(input int k, input logic [4:0] rd, input logic [3:0] t, input logic [31:0] v);
    cm_valid[k] = 1;
    c_rd[k] = rd;
    c_tag[k] = t;
    c_val[k] = v;
  endtask

  task automatic look(input logic [4:0] a, input logic [4:0] b);
    idle();
    rs1_idx = a;
    rs2_idx = b;
    #1;
  endtask

  initial begin
    rst = 1;
    idle();
    rs1_idx = 0;
    rs2_idx = 0;
    model_reset();
    #2 rst = 0;
    #1 chk("reset_cnt", 32'(busy_cnt), 32'h0);
    check_all();
    @(negedge clk);
    rst = 1;
    ren(5, 3);
    look(5, 0);
    chk("x5_busy_pre_rst", 32'(rs1_busy), 32'h1);
    rst = 0;
    #1 model_reset();
    chk("x5_val_rst", rs1_val, 32'h0);
    chk("x5_busy_rst", 32'(rs1_busy), 32'h0);
    chk("cnt_rst", 32'(busy_cnt), 32'h0);
    @(negedge clk);
    rst = 1;
    ren(3, 7);
    idle();
    cmt(0, 3, 7, 32'hDEADBEEF);
    tick();
    look(3, 0);
    chk("x3_commit_val", rs1_val, 32'hDEADBEEF);
    chk("x3_commit_busy", 32'(rs1_busy), 32'h0);
    chk("x3_commit_cnt", 32'(busy_cnt), 32'h0);
    ren(3, 2);
    ren(3, 9);
    idle();
    cmt(0, 3, 2, 32'h11);
    tick();
    look(3, 0);
    chk("stale_val", rs1_val, 32'h11);
    chk("stale_busy", 32'(rs1_busy), 32'h1);
    chk("stale_tag", 32'(rs1_tag), 32'h9);
    chk("stale_cnt", 32'(busy_cnt), 32'h1);
    ren(4, 5);
    idle();
    cmt(0, 4, 5, 32'h44);
    ren_valid = 1;
    ren_rd = 4;
    ren_tag = 6;
    tick();
    look(4, 0);
    chk("renwin_busy", 32'(rs1_busy), 32'h1);
    chk("renwin_tag", 32'(rs1_tag), 32'h6);
    chk("renwin_val", rs1_val, 32'h44);
    chk("renwin_cnt", 32'(busy_cnt), 32'h2);
    ren(8, 1);
    idle();
    cmt(0, 8, 3, 32'hA);
    cmt(1, 8, 1, 32'hB);
    tick();
    look(8, 0);
    chk("dual_val", rs1_val, 32'hB);
    chk("dual_busy", 32'(rs1_busy), 32'h0);
    chk("dual_cnt", 32'(busy_cnt), 32'h2);
    idle();
    rdy = 0;
    ren_valid = 1;
    ren_rd = 6;
    ren_tag = 2;
    tick();
    look(6, 0);
    chk("hold_busy", 32'(rs1_busy), 32'h0);
    chk("hold_cnt", 32'(busy_cnt), 32'h2);
    ren(0, 5);
    look(0, 0);
    chk("x0_val", rs1_val, 32'h0);
    chk("x0_busy", 32'(rs1_busy), 32'h0);
    chk("x0_cnt", 32'(busy_cnt), 32'h2);
    ren(1, 1);
    ren(2, 2);
    ren(7, 3);
    look(1, 7);
    chk("preflush_cnt", 32'(busy_cnt), 32'h5);
    idle();
    flush = 1;
    cmt(0, 2, 2, 32'h55);
    ren_valid = 1;
    ren_rd = 9;
    ren_tag = 4;
    tick();
    look(2, 1);
    chk("flush_cnt", 32'(busy_cnt), 32'h0);
    chk("flush_x2_val", rs1_val, 32'h55);
    chk("flush_x2_busy", 32'(rs1_busy), 32'h0);
    chk("flush_x1_val", rs2_val, 32'h0);
    chk("flush_x1_busy", 32'(rs2_busy), 32'h0);
    look(7, 9);
    chk("flush_x7_busy", 32'(rs1_busy), 32'h0);
    chk("flush_x9_busy", 32'(rs2_busy), 32'h0);
    for (int i = 0; i < 800; i++) begin
      idle();
      rdy = ($urandom_range(0, 9) != 0);
      flush = ($urandom_range(0, 24) == 0);
      ren_valid = 1'($urandom_range(0, 1));
      ren_rd = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 7));
      ren_tag = 4'($urandom_range(0, 15));
      for (int k = 0; k < 2; k++) begin
        cm_valid[k] = 1'($urandom_range(0, 1));
        c_rd[k] = 5'($urandom_range(0, 7));
        c_tag[k] = $urandom_range(0, 1) ? m_tag[c_rd[k]] : 4'($urandom_range(0, 15));
        c_val[k] = $urandom;
      end
      rs1_idx = 5'($urandom_range(0, 7));
      rs2_idx = 5'($urandom_range(0, 31));
      tick();
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
